hazard_control_unit: RTL
========================

// Module: hazard_control_unit
// PURPOSE
// Pipeline sequencer for the 5-stage core (FETCH..WRITEBACK). Tracks in-flight destination registers,
// drives fetch->decode / decode->execute flop enables, operand forwarding selects, load-use stalls,
// taken-jump fetch flush, and start/wait sequencing of the multi-cycle M-extension unit. Sits beside decode.
// PARAMETERS
// REGISTER_SIZE  5   register address width
// FWD_SEL_SIZE   2   forwarding select width
// MD_TIMEOUT     64  max MD_WAIT cycles before abort (>=2)
// STALL_CNT_W    32  stall perf-counter width
// PORTS
// clk            in   1              clock
// rst            in   1              synchronous active-high reset
// dec_valid      in   1              decode stage holds a real instruction
// dec_rs1/rs2    in   REGISTER_SIZE  source register addresses
// dec_rs1_used   in   1              rs1 read by instruction (likewise dec_rs2_used)
// dec_rs2_used   in   1
// dec_rd         in   REGISTER_SIZE  destination register
// dec_rd_we      in   1              instruction writes rd
// dec_is_load    in   1              instruction is a load
// dec_is_muldiv  in   1              instruction uses the M-extension unit
// jbl_taken      in   1              jump/branch resolved taken in decode
// md_done        in   1              M unit result valid (1-cycle pulse)
// f_to_d_enable_ff  out 1            enable fetch->decode flop
// d_to_e_enable_ff  out 1            enable decode->execute flop
// bubble_execute out  1              core loads NOP controls into execute flop
// flush_decode   out  1              core loads NOP into fetch->decode flop
// fwd_sel_a      out  FWD_SEL_SIZE   operand A source (fwd_src_t)
// fwd_sel_b      out  FWD_SEL_SIZE   operand B source
// md_start       out  1              1-cycle start pulse to M unit
// md_abort       out  1              1-cycle pulse on timeout
// stall_count    out  STALL_CNT_W    cycles with d_to_e_enable_ff=0
// BEHAVIOUR
// - Reset: state RUN, shadow EX/MEM entries invalid, timeout ctr 0, stall_count 0; outputs then:
//   enables=1, bubble/flush/md_start/md_abort=0, fwd_sel_*=DECODE_RF_OPERAND.
// - Shadow regs {valid,rd,we,is_load} for EXECUTE and MEMORY_ACCESS. EX <= decode fields when
//   d_to_e_enable_ff & !bubble_execute, else valid=0. MEM <= EX every cycle.
// - Forwarding (comb, per used operand, rs!=0): EX match & !EX.is_load -> EXECUTE_ALU_OPERAND;
//   else MEM match -> MEM_ACCESS_DM_OPERAND if MEM.is_load else MEM_ACCESS_ALU_OPERAND;
//   else DECODE_RF_OPERAND. EX has priority (youngest). Match = valid & we & rd==rs. x0 never forwarded.
// - RUN: load-use (EX.is_load match on used rs) -> f_to_d=0, d_to_e=0, bubble=1, go LOAD_STALL.
//   Else dec_valid & dec_is_muldiv -> md_start=1, f_to_d=0, d_to_e=0, bubble=1, go MD_WAIT.
//   Else jbl_taken & dec_valid -> flush_decode=1 (1 cycle); enables stay 1.
// - LOAD_STALL: exactly 1 cycle; enables=1 (load now in MEM, DM forward), -> RUN, re-evaluated in RUN.
// - MD_WAIT: f_to_d=0, d_to_e=0, bubble=1 until md_done; on md_done: d_to_e=1, f_to_d=1, bubble=0, -> RUN.
//   Timeout ctr increments each MD_WAIT cycle; at MD_TIMEOUT-1 without md_done: md_abort=1,
//   bubble=1, enables=1 (instruction dropped), -> RUN. md_done same cycle as timeout: done wins.
//   md_done outside MD_WAIT ignored.
// - jbl_taken ignored while any stall asserted (branch re-resolves once operands ready).
// - Load-use and muldiv same cycle: load-use first, muldiv start on following RUN cycle.
// - stall_count: +1 each cycle d_to_e_enable_ff=0; saturates at all-ones.
// - rst mid-MD_WAIT: immediate return to reset values, no md_abort pulse.
// STRUCTURE
// - Package cpu_pkg: fwd_src_t {DECODE_RF_OPERAND, MEM_ACCESS_DM_OPERAND, EXECUTE_ALU_OPERAND,
//   MEM_ACCESS_ALU_OPERAND}, hz_state_t {RUN, LOAD_STALL, MD_WAIT}, shadow entry struct.
// - Sub-module hazard_fwd_select (combinational, per operand), instantiated for rs1 and rs2.
// TESTING
// - ADD x5 in EX, decode rs1=x5 -> fwd_sel_a=EXECUTE_ALU_OPERAND; one cycle later MEM_ACCESS_ALU_OPERAND.
// - LD x7 in EX, decode rs2=x7 -> 1 cycle enables=0,bubble=1, stall_count=1; next fwd_sel_b=MEM_ACCESS_DM_OPERAND.
// - rs1=x0 with EX rd=x0 we=1 -> fwd_sel_a=DECODE_RF_OPERAND, no stall.
// - MUL in decode, md_done after 5 cycles -> md_start 1 pulse, 5 stall cycles, then d_to_e=1, RUN.
// - MUL, md_done never -> md_abort at cycle MD_TIMEOUT (64), back to RUN; rst during MD_WAIT -> no abort.
// - jbl_taken in RUN -> flush_decode 1 cycle; jbl_taken during LOAD_STALL -> flush_decode=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the pipeline hazard/sequencing logic.
//   fwd_src_t  : operand source select driven to the execute-stage operand muxes
//   hz_state_t : hazard sequencer state
//   shadow_t   : copy of the control fields of the instruction in EXECUTE or
//                MEMORY_ACCESS, used for dependency checks
package cpu_pkg;

  // Shadow entries are sized for the core's 32-entry register file.
  localparam int REG_ADDR_W = 5;
  localparam int FWD_SEL_W  = 2;

  typedef enum logic [FWD_SEL_W-1:0] {
    DECODE_RF_OPERAND      = 2'd0,
    MEM_ACCESS_DM_OPERAND  = 2'd1,
    EXECUTE_ALU_OPERAND    = 2'd2,
    MEM_ACCESS_ALU_OPERAND = 2'd3
  } fwd_src_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MD_WAIT    = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  is_load;
  } shadow_t;

endpackage

// File: rtl/hazard_fwd_select.sv
// Operand forwarding select for one source operand (purely combinational).
// Ports:
//   rs, rs_used               : source register address and whether it is read
//   ex_* / mem_*              : shadow entry of the EXECUTE / MEMORY_ACCESS stage
//   fwd_sel                   : chosen operand source (fwd_src_t encoding)
//   load_use                  : operand depends on a load still in EXECUTE
// EXECUTE is the youngest producer so it wins over MEMORY_ACCESS. A load in
// EXECUTE has no data yet; that case is reported through load_use and the
// select falls through to the older stage. x0 is hardwired zero and is never
// forwarded.
module hazard_fwd_select
  import cpu_pkg::*;
#(
  parameter int REGISTER_SIZE = 5,
  parameter int FWD_SEL_SIZE  = 2
) (
  input  logic [REGISTER_SIZE-1:0] rs,
  input  logic                     rs_used,
  input  logic                     ex_valid,
  input  logic [REGISTER_SIZE-1:0] ex_rd,
  input  logic                     ex_we,
  input  logic                     ex_is_load,
  input  logic                     mem_valid,
  input  logic [REGISTER_SIZE-1:0] mem_rd,
  input  logic                     mem_we,
  input  logic                     mem_is_load,
  output logic [FWD_SEL_SIZE-1:0]  fwd_sel,
  output logic                     load_use
);

  logic     rs_live;
  logic     ex_match;
  logic     mem_match;
  fwd_src_t sel;

  assign rs_live   = rs_used && (rs != '0);
  assign ex_match  = rs_live && ex_valid && ex_we && (ex_rd == rs);
  assign mem_match = rs_live && mem_valid && mem_we && (mem_rd == rs);

  always_comb begin
    sel = DECODE_RF_OPERAND;
    if (ex_match && !ex_is_load) begin
      sel = EXECUTE_ALU_OPERAND;
    end else if (mem_match) begin
      sel = mem_is_load ? MEM_ACCESS_DM_OPERAND : MEM_ACCESS_ALU_OPERAND;
    end
  end

  assign fwd_sel  = FWD_SEL_SIZE'(sel);
  assign load_use = ex_match && ex_is_load;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage core, sitting beside decode.
// Tracks the destination registers of the instructions in EXECUTE and
// MEMORY_ACCESS, drives the fetch->decode and decode->execute flop enables,
// the operand forwarding selects, load-use stalls, taken-jump fetch flush and
// the start/wait handshake of the multi-cycle M-extension unit.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   dec_*                     : fields of the instruction currently in decode
//   jbl_taken                 : jump/branch resolved taken in decode
//   md_done                   : M unit result valid (single-cycle pulse)
//   f_to_d_enable_ff          : enable for the fetch->decode flop
//   d_to_e_enable_ff          : enable for the decode->execute flop
//   bubble_execute            : load NOP controls into the execute flop
//   flush_decode              : load NOP into the fetch->decode flop
//   fwd_sel_a / fwd_sel_b     : operand A/B source (fwd_src_t)
//   md_start / md_abort       : single-cycle start / timeout pulses to the M unit
//   stall_count               : saturating count of cycles with d_to_e_enable_ff=0
//   dbg_state                 : current sequencer state (hz_state_t encoding)
// Handshake with the M unit: md_start is a one-cycle request issued from RUN;
// the unit answers with a one-cycle md_done pulse, which is only honoured in
// MD_WAIT. If no md_done arrives within MD_TIMEOUT cycles the instruction is
// dropped with a one-cycle md_abort.
module hazard_control_unit
  import cpu_pkg::*;
#(
  parameter int REGISTER_SIZE = 5,
  parameter int FWD_SEL_SIZE  = 2,
  parameter int MD_TIMEOUT    = 64,
  parameter int STALL_CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec_valid,
  input  logic [REGISTER_SIZE-1:0] dec_rs1,
  input  logic [REGISTER_SIZE-1:0] dec_rs2,
  input  logic                     dec_rs1_used,
  input  logic                     dec_rs2_used,
  input  logic [REGISTER_SIZE-1:0] dec_rd,
  input  logic                     dec_rd_we,
  input  logic                     dec_is_load,
  input  logic                     dec_is_muldiv,
  input  logic                     jbl_taken,
  input  logic                     md_done,
  output logic                     f_to_d_enable_ff,
  output logic                     d_to_e_enable_ff,
  output logic                     bubble_execute,
  output logic                     flush_decode,
  output logic [FWD_SEL_SIZE-1:0]  fwd_sel_a,
  output logic [FWD_SEL_SIZE-1:0]  fwd_sel_b,
  output logic                     md_start,
  output logic                     md_abort,
  output logic [STALL_CNT_W-1:0]   stall_count,
  output logic [1:0]               dbg_state
);

  localparam int MD_CTR_W = $clog2(MD_TIMEOUT);

  hz_state_t               state_q, state_d;
  shadow_t                 ex_q, mem_q;
  logic [MD_CTR_W-1:0]     md_ctr_q, md_ctr_d;
  logic [STALL_CNT_W-1:0]  stall_count_q;

  logic                    load_use_a, load_use_b, load_use;
  logic [FWD_SEL_SIZE-1:0] fwd_raw_a, fwd_raw_b;
  logic                    dec_muldiv;

  // ---------------------------------------------------------------------------
  // Forwarding / dependency detection, one instance per source operand
  // ---------------------------------------------------------------------------
  hazard_fwd_select #(
    .REGISTER_SIZE (REGISTER_SIZE),
    .FWD_SEL_SIZE  (FWD_SEL_SIZE)
  ) u_fwd_rs1 (
    .rs          (dec_rs1),
    .rs_used     (dec_rs1_used),
    .ex_valid    (ex_q.valid),
    .ex_rd       (ex_q.rd),
    .ex_we       (ex_q.we),
    .ex_is_load  (ex_q.is_load),
    .mem_valid   (mem_q.valid),
    .mem_rd      (mem_q.rd),
    .mem_we      (mem_q.we),
    .mem_is_load (mem_q.is_load),
    .fwd_sel     (fwd_raw_a),
    .load_use    (load_use_a)
  );

  hazard_fwd_select #(
    .REGISTER_SIZE (REGISTER_SIZE),
    .FWD_SEL_SIZE  (FWD_SEL_SIZE)
  ) u_fwd_rs2 (
    .rs          (dec_rs2),
    .rs_used     (dec_rs2_used),
    .ex_valid    (ex_q.valid),
    .ex_rd       (ex_q.rd),
    .ex_we       (ex_q.we),
    .ex_is_load  (ex_q.is_load),
    .mem_valid   (mem_q.valid),
    .mem_rd      (mem_q.rd),
    .mem_we      (mem_q.we),
    .mem_is_load (mem_q.is_load),
    .fwd_sel     (fwd_raw_b),
    .load_use    (load_use_b)
  );

  assign load_use   = load_use_a || load_use_b;
  assign dec_muldiv = dec_valid && dec_is_muldiv;

  // While reset is held the shadow entries may still carry stale contents, so
  // the selects are pinned to the register file.
  assign fwd_sel_a = rst ? FWD_SEL_SIZE'(DECODE_RF_OPERAND) : fwd_raw_a;
  assign fwd_sel_b = rst ? FWD_SEL_SIZE'(DECODE_RF_OPERAND) : fwd_raw_b;

  // ---------------------------------------------------------------------------
  // Sequencer: next state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    md_ctr_d         = md_ctr_q;
    f_to_d_enable_ff = 1'b1;
    d_to_e_enable_ff = 1'b1;
    bubble_execute   = 1'b0;
    flush_decode     = 1'b0;
    md_start         = 1'b0;
    md_abort         = 1'b0;

    // Outputs sit at their idle values while reset is held; in particular a
    // reset that lands on the timeout cycle must not emit md_abort.
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (load_use) begin
            f_to_d_enable_ff = 1'b0;
            d_to_e_enable_ff = 1'b0;
            bubble_execute   = 1'b1;
            state_d          = LOAD_STALL;
          end else if (dec_muldiv) begin
            md_start         = 1'b1;
            f_to_d_enable_ff = 1'b0;
            d_to_e_enable_ff = 1'b0;
            bubble_execute   = 1'b1;
            md_ctr_d         = '0;
            state_d          = MD_WAIT;
          end else if (jbl_taken && dec_valid) begin
            // Only reached when nothing is stalling, so a branch whose
            // operands are not ready yet never flushes.
            flush_decode = 1'b1;
          end
        end

        LOAD_STALL: begin
          // The load has moved to MEMORY_ACCESS and its data can now be
          // forwarded, so the dependent instruction normally advances. A
          // muldiv must not slip into execute without its start pulse, so it
          // is held for this one cycle and started from RUN next cycle.
          state_d = RUN;
          if (dec_muldiv) begin
            f_to_d_enable_ff = 1'b0;
            d_to_e_enable_ff = 1'b0;
            bubble_execute   = 1'b1;
          end
        end

        MD_WAIT: begin
          if (md_done) begin
            // A result arriving on the timeout cycle is still accepted.
            state_d = RUN;
          end else if (md_ctr_q == MD_CTR_W'(MD_TIMEOUT - 1)) begin
            // Give up: let the pipeline move on with a NOP in place of the
            // muldiv instruction.
            md_abort       = 1'b1;
            bubble_execute = 1'b1;
            state_d        = RUN;
          end else begin
            f_to_d_enable_ff = 1'b0;
            d_to_e_enable_ff = 1'b0;
            bubble_execute   = 1'b1;
            md_ctr_d         = md_ctr_q + 1'b1;
          end
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, shadow registers, timeout counter and stall counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      ex_q          <= '0;
      mem_q         <= '0;
      md_ctr_q      <= '0;
      stall_count_q <= '0;
    end else begin
      state_q  <= state_d;
      md_ctr_q <= md_ctr_d;
      mem_q    <= ex_q;

      if (d_to_e_enable_ff && !bubble_execute) begin
        ex_q.valid   <= dec_valid;
        ex_q.rd      <= dec_rd;
        ex_q.we      <= dec_rd_we;
        ex_q.is_load <= dec_is_load;
      end else begin
        ex_q <= '0;
      end

      if (!d_to_e_enable_ff && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + 1'b1;
      end
    end
  end

  assign stall_count = stall_count_q;
  assign dbg_state   = state_q;

endmodule
